// File: rtl/ctrl_gen_multi.sv
// -----------------------------------------------------------------------------
// ctrl_gen_multi
// -----------------------------------------------------------------------------
// Clock-setting controller. One-shot button pulses are turned into a
// display-mode selector (NORMAL state) or into a field-setting machine (SET
// state) over NUM_FIELDS counter fields, field 0 being the least significant.
// Sits between the button one-shot/debounce stage and the time counters and
// display mux. Every output is registered: a button pulse presented in one
// cycle shows up on the outputs right after the next rising clock edge.
//
// Action priority within a cycle: btnl > btnr > (btnu xor btnd). btnu and
// btnd together cancel each other. Lower-priority pulses are dropped.
//
// Parameters
//   NUM_FIELDS      number of settable fields (2..8)
//   NUM_MODES       number of display modes cycled in NORMAL (2..8)
//   RST_FIELD_MASK  bit i set: up/down on field i gives field_rst[i]
//   TIMEOUT_CYC     idle cycles in SET before auto-return to NORMAL, 0 = off
//   REPEAT_DLY      hold cycles before the first auto-repeat pulse
//   REPEAT_PER      cycles between subsequent auto-repeat pulses
//
// Build option
//   AUTO_REPEAT_EN  when defined, holding exactly one of btnu_lvl/btnd_lvl in
//                   SET generates repeated up/down actions. When undefined the
//                   level inputs are ignored and no repeat logic is built.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous reset, active low
//   btnr       in   one-shot: next display mode (NORMAL) / next field (SET)
//   btnl       in   one-shot: enter / leave SET
//   btnu       in   one-shot: increment selected field
//   btnd       in   one-shot: decrement selected field
//   btnu_lvl   in   debounced level of the up button
//   btnd_lvl   in   debounced level of the down button
//   mask_1hz   in   1 Hz blink mask for the selected field
//   disp_mode  out  current display mode (held while in SET)
//   set_mode   out  1 while in SET
//   field_sel  out  selected field (0 outside SET)
//   field_inc  out  one-cycle, one-hot increment pulse
//   field_dec  out  one-cycle, one-hot decrement pulse
//   field_rst  out  one-cycle, one-hot reset pulse
//   disp_en    out  per-field display enable, 0 = blanked
// -----------------------------------------------------------------------------
module ctrl_gen_multi #(
  parameter int unsigned           NUM_FIELDS     = 3,
  parameter int unsigned           NUM_MODES      = 2,
  // Default marks only field 0 (seconds) as reset-on-adjust.
  parameter logic [NUM_FIELDS-1:0] RST_FIELD_MASK = NUM_FIELDS'(1),
  parameter int unsigned           TIMEOUT_CYC    = 0,
  parameter int unsigned           REPEAT_DLY     = 50_000_000,
  parameter int unsigned           REPEAT_PER     = 10_000_000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          btnr,
  input  logic                          btnl,
  input  logic                          btnu,
  input  logic                          btnd,
  input  logic                          btnu_lvl,
  input  logic                          btnd_lvl,
  input  logic                          mask_1hz,
  output logic [$clog2(NUM_MODES)-1:0]  disp_mode,
  output logic                          set_mode,
  output logic [$clog2(NUM_FIELDS)-1:0] field_sel,
  output logic [NUM_FIELDS-1:0]         field_inc,
  output logic [NUM_FIELDS-1:0]         field_dec,
  output logic [NUM_FIELDS-1:0]         field_rst,
  output logic [NUM_FIELDS-1:0]         disp_en
);

  localparam int unsigned MW = $clog2(NUM_MODES);
  localparam int unsigned FW = $clog2(NUM_FIELDS);

  // Timeout counter runs 0 .. TIMEOUT_CYC-1; keep at least one bit so the
  // disabled configuration still elaborates cleanly.
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_SET    = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [MW-1:0]         mode_q, mode_d;
  logic [FW-1:0]         sel_q, sel_d;
  logic [NUM_FIELDS-1:0] inc_q, inc_d;
  logic [NUM_FIELDS-1:0] dec_q, dec_d;
  logic [NUM_FIELDS-1:0] frst_q, frst_d;
  logic [NUM_FIELDS-1:0] en_q, en_d;
  logic [TW-1:0]         tmo_q, tmo_d;

  // Repeat-generated up/down requests; tied low when auto-repeat is not built.
  logic rep_up;
  logic rep_dn;

  // Decoded single action for this cycle, already priority-resolved.
  logic up_req, dn_req;
  logic act_l, act_r, act_u, act_d;
  logic [NUM_FIELDS-1:0] sel_onehot;

  assign up_req = btnu | rep_up;
  assign dn_req = btnd | rep_dn;
  assign act_l  = btnl;
  assign act_r  = btnr & ~btnl;
  assign act_u  = up_req & ~dn_req & ~btnl & ~btnr;
  assign act_d  = dn_req & ~up_req & ~btnl & ~btnr;

  assign sel_onehot = NUM_FIELDS'(1) << sel_q;

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case/if tree can leave one unassigned and infer a latch.
    state_d = state_q;
    mode_d  = mode_q;
    sel_d   = sel_q;
    inc_d   = '0;
    dec_d   = '0;
    frst_d  = '0;
    tmo_d   = '0;

    unique case (state_q)
      ST_NORMAL: begin
        if (act_l) begin
          state_d = ST_SET;
          sel_d   = '0;
        end else if (act_r) begin
          mode_d = (mode_q == MW'(NUM_MODES - 1)) ? '0 : mode_q + MW'(1);
        end
        // Up/down are meaningless outside SET and are dropped.
      end

      ST_SET: begin
        if (act_l) begin
          state_d = ST_NORMAL;
          sel_d   = '0;
        end else if (act_r) begin
          sel_d = (sel_q == FW'(NUM_FIELDS - 1)) ? '0 : sel_q + FW'(1);
        end else if (act_u || act_d) begin
          if (RST_FIELD_MASK[sel_q]) begin
            frst_d = sel_onehot;
          end else if (act_u) begin
            inc_d = sel_onehot;
          end else begin
            dec_d = sel_onehot;
          end
        end else if (TIMEOUT_CYC > 0) begin
          // Idle cycle: either advance the timeout or, on its last count,
          // drop back to NORMAL. Any accepted action above restarts it at 0.
          if (tmo_q == TMO_LAST) begin
            state_d = ST_NORMAL;
            sel_d   = '0;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
      end

      default: begin
        state_d = ST_NORMAL;
        sel_d   = '0;
      end
    endcase

    // Blank-blink only the field that will be selected after this edge, so
    // disp_en always agrees with the registered set_mode/field_sel.
    for (int i = 0; i < int'(NUM_FIELDS); i++) begin
      en_d[i] = ((state_d == ST_SET) && (sel_d == FW'(i))) ? mask_1hz : 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_NORMAL;
      mode_q  <= '0;
      sel_q   <= '0;
      inc_q   <= '0;
      dec_q   <= '0;
      frst_q  <= '0;
      en_q    <= '1;
      tmo_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values; blocking here would let later lines see updated state.
      state_q <= state_d;
      mode_q  <= mode_d;
      sel_q   <= sel_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      frst_q  <= frst_d;
      en_q    <= en_d;
      tmo_q   <= tmo_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Hold-to-repeat
  // ---------------------------------------------------------------------------
`ifdef AUTO_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int unsigned RW      = $clog2(REP_MAX + 1);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_arm_q, rep_arm_d;  // first delay already elapsed
  logic          rep_one;
  logic          rep_fire;
  logic          rep_hold;

  assign rep_one  = btnu_lvl ^ btnd_lvl;

  // rep_cnt_q is the number of cycles this hold has lasted so far; the first
  // pulse lands after REPEAT_DLY of them, later ones every REPEAT_PER.
  assign rep_fire = (state_q == ST_SET) && rep_one &&
                    (rep_cnt_q == (rep_arm_q ? RW'(REPEAT_PER) : RW'(REPEAT_DLY)));
  assign rep_up   = rep_fire & btnu_lvl;
  assign rep_dn   = rep_fire & btnd_lvl;

  // The hold survives only while SET and the selected field stay put.
  assign rep_hold = (state_q == ST_SET) && rep_one &&
                    (state_d == ST_SET) && (sel_d == sel_q);

  always_comb begin
    rep_cnt_d = '0;
    rep_arm_d = 1'b0;
    if (rep_hold) begin
      rep_cnt_d = rep_fire ? RW'(1) : rep_cnt_q + RW'(1);
      rep_arm_d = rep_arm_q | rep_fire;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q <= '0;
      rep_arm_q <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      rep_arm_q <= rep_arm_d;
    end
  end
`else
  assign rep_up = 1'b0;
  assign rep_dn = 1'b0;

  // Level inputs and repeat timing exist only for port/parameter
  // compatibility in this build.
  localparam int unsigned rep_cfg_unused = REPEAT_DLY + REPEAT_PER;
  logic lvl_unused;
  assign lvl_unused = btnu_lvl | btnd_lvl;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign disp_mode = mode_q;
  assign set_mode  = (state_q == ST_SET);
  assign field_sel = sel_q;
  assign field_inc = inc_q;
  assign field_dec = dec_q;
  assign field_rst = frst_q;
  assign disp_en   = en_q;

endmodule

// File: tb/tb_ctrl_gen_multi.sv
// -----------------------------------------------------------------------------
// tb_ctrl_gen_multi
// Self-checking bench for ctrl_gen_multi (3 fields, 3 modes, field 0 reset-on-
// adjust, 1000-cycle timeout, repeat 100/20). A behavioural model tracks the
// controller in terms of "in SET", mode, selected field, idle cycles and held
// cycles, and every clock its predicted outputs are compared with the DUT.
// -----------------------------------------------------------------------------
module tb_ctrl_gen_multi;

  localparam int NF   = 3;
  localparam int NM   = 3;
  localparam int TMO  = 1000;
  localparam int RDLY = 100;
  localparam int RPER = 20;
  localparam logic [NF-1:0] RMASK = 3'b001;
`ifdef AUTO_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif
  localparam int VW = 2 + 1 + 2 + 4 * NF;

  logic          clk;
  logic          rst_n;
  logic          btnr, btnl, btnu, btnd;
  logic          btnu_lvl, btnd_lvl, mask_1hz;
  logic [1:0]    disp_mode;
  logic          set_mode;
  logic [1:0]    field_sel;
  logic [NF-1:0] field_inc, field_dec, field_rst, disp_en;

  ctrl_gen_multi #(
    .NUM_FIELDS     (NF),
    .NUM_MODES      (NM),
    .RST_FIELD_MASK (RMASK),
    .TIMEOUT_CYC    (TMO),
    .REPEAT_DLY     (RDLY),
    .REPEAT_PER     (RPER)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btnr      (btnr),
    .btnl      (btnl),
    .btnu      (btnu),
    .btnd      (btnd),
    .btnu_lvl  (btnu_lvl),
    .btnd_lvl  (btnd_lvl),
    .mask_1hz  (mask_1hz),
    .disp_mode (disp_mode),
    .set_mode  (set_mode),
    .field_sel (field_sel),
    .field_inc (field_inc),
    .field_dec (field_dec),
    .field_rst (field_rst),
    .disp_en   (disp_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit            m_set;
  int            m_mode, m_sel;
  int            m_idle;   // consecutive SET cycles without an accepted action
  int            m_hold;   // cycles one level has been held on this field
  logic [NF-1:0] e_inc, e_dec, e_rst, e_en;

  task automatic model_reset();
    m_set  = 1'b0;
    m_mode = 0;
    m_sel  = 0;
    m_idle = 0;
    m_hold = 0;
    e_inc  = '0;
    e_dec  = '0;
    e_rst  = '0;
    e_en   = '1;
  endtask

  task automatic model_step(input bit l, input bit r, input bit u, input bit d,
                            input bit ul, input bit dl, input bit mk);
    bit prev_set = m_set;
    int prev_sel = m_sel;
    bit rep_u = 1'b0;
    bit rep_d = 1'b0;
    bit act   = 1'b0;
    bit up, dn;
    e_inc = '0;
    e_dec = '0;
    e_rst = '0;
    if (REP_ON && m_set && (ul != dl) && m_hold >= RDLY && ((m_hold - RDLY) % RPER) == 0) begin
      rep_u = ul;
      rep_d = dl;
    end
    up = u | rep_u;
    dn = d | rep_d;
    if (l) begin
      m_set = !m_set;
      m_sel = 0;
      act   = 1'b1;
    end else if (r) begin
      if (m_set) m_sel = (m_sel + 1) % NF;
      else       m_mode = (m_mode + 1) % NM;
      act = 1'b1;
    end else if (m_set && (up != dn)) begin
      act = 1'b1;
      if (RMASK[m_sel]) e_rst[m_sel] = 1'b1;
      else if (up)      e_inc[m_sel] = 1'b1;
      else              e_dec[m_sel] = 1'b1;
    end
    if (!prev_set || act) begin
      m_idle = 0;
    end else begin
      m_idle++;
      if (m_idle == TMO) begin
        m_set = 1'b0;
        m_sel = 0;
      end
    end
    if (prev_set && m_set && prev_sel == m_sel && (ul != dl)) m_hold++;
    else                                                      m_hold = 0;
    e_en = '1;
    if (m_set) e_en[m_sel] = mk;
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [1:0] md = 2'(m_mode);
    logic [1:0] sl = 2'(m_sel);
    return {md, m_set, sl, e_inc, e_dec, e_rst, e_en};
  endfunction

  function automatic logic [VW-1:0] got_vec();
    return {disp_mode, set_mode, field_sel, field_inc, field_dec, field_rst, disp_en};
  endfunction

  // One clock with the given one-shots; levels and mask are taken as currently
  // driven. Outputs are sampled 1 time unit after the rising edge.
  task automatic step(input bit l, input bit r, input bit u, input bit d);
    btnl = l;
    btnr = r;
    btnu = u;
    btnd = d;
    model_step(l, r, u, d, btnu_lvl, btnd_lvl, mask_1hz);
    @(posedge clk);
    #1;
    btnl = 1'b0;
    btnr = 1'b0;
    btnu = 1'b0;
    btnd = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    btnl = 1'b1; btnr = 1'b1; btnu = 1'b0; btnd = 1'b0;
    btnu_lvl = 1'b1; btnd_lvl = 1'b0; mask_1hz = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (got_vec() !== {2'd0, 1'b0, 2'd0, 3'b000, 3'b000, 3'b000, 3'b111}) begin
      miscompares++;
      $display("FAIL reset_values: got %h, expected %h", got_vec(),
               {2'd0, 1'b0, 2'd0, 3'b000, 3'b000, 3'b000, 3'b111});
    end
    @(negedge clk);
    btnl = 1'b0; btnr = 1'b0; btnu_lvl = 1'b0;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 0);
      vectors++;
      if (got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_idle[%0d]: got %h, expected %h", i, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_mode_cycle();
    int exp_mode[3] = '{1, 2, 0};
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0);
      vectors++;
      if (got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL mode_cycle[%0d]: got %h, expected %h", i, got_vec(), exp_vec());
      end
      vectors++;
      if (disp_mode !== 2'(exp_mode[i]) || {field_inc, field_dec, field_rst} !== 9'b0 ||
          disp_en !== 3'b111) begin
        miscompares++;
        $display("FAIL mode_value[%0d]: got mode %0d en %b, expected mode %0d en 111",
                 i, disp_mode, disp_en, exp_mode[i]);
      end
    end
    // Up/down in NORMAL must do nothing.
    step(0, 0, 1, 0);
    vectors++;
    if (got_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL normal_up_ignored: got %h, expected %h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_field_sel();
    bit tl[5]      = '{1, 0, 0, 0, 1};
    bit tr[5]      = '{0, 1, 1, 1, 0};
    bit exp_set[5] = '{1, 1, 1, 1, 0};
    int exp_sel[5] = '{0, 1, 2, 0, 0};
    for (int i = 0; i < 5; i++) begin
      step(tl[i], tr[i], 0, 0);
      vectors++;
      if (got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL field_sel[%0d]: got %h, expected %h", i, got_vec(), exp_vec());
      end
      vectors++;
      if (set_mode !== exp_set[i] || field_sel !== 2'(exp_sel[i])) begin
        miscompares++;
        $display("FAIL field_sel_value[%0d]: got set %b sel %0d, expected set %b sel %0d",
                 i, set_mode, field_sel, exp_set[i], exp_sel[i]);
      end
    end
  endtask

  typedef struct packed {
    logic          l, r, u, d;
    logic [3*NF-1:0] pulses;   // {inc, dec, rst}
  } pvec_t;

  task automatic test_pulses();
    pvec_t tbl[11];
    tbl = '{
      '{1'b1, 1'b0, 1'b0, 1'b0, 9'b000_000_000},  // enter SET, sel 0
      '{1'b0, 1'b0, 1'b1, 1'b0, 9'b000_000_001},  // up on masked field 0
      '{1'b0, 1'b0, 1'b0, 1'b0, 9'b000_000_000},  // pulse lasts one cycle
      '{1'b0, 1'b1, 1'b0, 1'b0, 9'b000_000_000},  // sel 1
      '{1'b0, 1'b0, 1'b1, 1'b0, 9'b010_000_000},  // inc field 1
      '{1'b0, 1'b1, 1'b0, 1'b0, 9'b000_000_000},  // sel 2
      '{1'b0, 1'b0, 1'b0, 1'b1, 9'b000_100_000},  // dec field 2
      '{1'b0, 1'b0, 1'b1, 1'b1, 9'b000_000_000},  // up+down cancel
      '{1'b0, 1'b1, 1'b1, 1'b0, 9'b000_000_000},  // btnr wins, sel 0
      '{1'b0, 1'b0, 1'b0, 1'b1, 9'b000_000_001},  // down on masked field 0
      '{1'b1, 1'b0, 1'b1, 1'b0, 9'b000_000_000}   // btnl wins, leave SET
    };
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].l, tbl[i].r, tbl[i].u, tbl[i].d);
      vectors++;
      if (got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL pulses[%0d]: got %h, expected %h", i, got_vec(), exp_vec());
      end
      vectors++;
      if ({field_inc, field_dec, field_rst} !== tbl[i].pulses) begin
        miscompares++;
        $display("FAIL pulse_value[%0d]: got %b, expected %b", i,
                 {field_inc, field_dec, field_rst}, tbl[i].pulses);
      end
    end
  endtask

  task automatic test_blink();
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 600; i++) begin
      if (i % 37 == 0) mask_1hz = ~mask_1hz;
      step(0, 0, 0, 0);
      vectors++;
      if (got_vec() !== exp_vec() || disp_en !== {1'b1, mask_1hz, 1'b1}) begin
        miscompares++;
        $display("FAIL blink[%0d]: got %h en %b, expected %h en %b", i, got_vec(),
                 disp_en, exp_vec(), {1'b1, mask_1hz, 1'b1});
      end
    end
    // Asynchronous reset between clock edges.
    mask_1hz = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (set_mode !== 1'b0 || field_sel !== 2'd0 || disp_en !== 3'b111) begin
      miscompares++;
      $display("FAIL async_reset: got set %b sel %0d en %b, expected set 0 sel 0 en 111",
               set_mode, field_sel, disp_en);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_timeout();
    step(1, 0, 0, 0);
    for (int i = 0; i < 499; i++) step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 999; i++) begin
      step(0, 0, 0, 0);
      vectors++;
      if (got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL timeout_idle[%0d]: got %h, expected %h", i, got_vec(), exp_vec());
      end
    end
    vectors++;
    if (set_mode !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_early: got set %b, expected 1", set_mode);
    end
    step(0, 0, 0, 0);
    vectors++;
    if (set_mode !== 1'b0 || field_sel !== 2'd0 || got_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL timeout_expire: got set %b sel %0d, expected set 0 sel 0",
               set_mode, field_sel);
    end
    begin
      int mode_before = m_mode;
      step(1, 1, 0, 0);
      vectors++;
      if (set_mode !== 1'b1 || disp_mode !== 2'(mode_before) || got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL btnl_over_btnr: got set %b mode %0d, expected set 1 mode %0d",
                 set_mode, disp_mode, mode_before);
      end
    end
    step(1, 0, 0, 0);
  endtask

  task automatic test_repeat();
    int pulses = 0;
    int exp_cnt = REP_ON ? 5 : 0;
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    btnu_lvl = 1'b1;
    for (int i = 0; i < 200; i++) begin
      bit exp_p = REP_ON && i >= RDLY && ((i - RDLY) % RPER) == 0;
      step(0, 0, 0, 0);
      if (field_inc[1] === 1'b1) pulses++;
      vectors++;
      if (got_vec() !== exp_vec() || field_inc !== (exp_p ? 3'b010 : 3'b000)) begin
        miscompares++;
        $display("FAIL repeat_hold[%0d]: got %h inc %b, expected %h inc %b", i, got_vec(),
                 field_inc, exp_vec(), exp_p ? 3'b010 : 3'b000);
      end
    end
    btnu_lvl = 1'b0;
    vectors++;
    if (pulses !== exp_cnt) begin
      miscompares++;
      $display("FAIL repeat_count: got %0d pulses, expected %0d", pulses, exp_cnt);
    end
    step(1, 0, 0, 0);
  endtask

  task automatic test_random();
    // Busy phase: frequent buttons, held levels long enough to reach repeats.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(79) == 0) btnu_lvl = ~btnu_lvl;
      if ($urandom_range(79) == 0) btnd_lvl = ~btnd_lvl;
      if ($urandom_range(29) == 0) mask_1hz = ~mask_1hz;
      step($urandom_range(299) == 0, $urandom_range(24) == 0,
           $urandom_range(11) == 0, $urandom_range(11) == 0);
      vectors++;
      if (got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random_busy[%0d]: got %h, expected %h", i, got_vec(), exp_vec());
      end
    end
    // Quiet phase: sparse buttons so SET sessions run into the timeout.
    btnu_lvl = 1'b0;
    btnd_lvl = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(29) == 0) mask_1hz = ~mask_1hz;
      step($urandom_range(399) == 0, $urandom_range(1499) == 0,
           $urandom_range(1499) == 0, $urandom_range(1499) == 0);
      vectors++;
      if (got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random_quiet[%0d]: got %h, expected %h", i, got_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    btnr = 1'b0; btnl = 1'b0; btnu = 1'b0; btnd = 1'b0;
    btnu_lvl = 1'b0; btnd_lvl = 1'b0; mask_1hz = 1'b0;
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_mode_cycle();
    test_field_sel();
    test_pulses();
    test_blink();
    test_timeout();
    test_repeat();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
